instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
- REQ-001 Parameter: HALT_OP, default 7'b1010101, opcode value that stops fetch.
- REQ-002 Parameter: NOP_WORD, default 32'h0000_0000, instruction presented when no valid fetch exists.
- REQ-003 One clock; reset is asynchronous and active-high.
- REQ-004 clk  in  1  rising-edge clock.
- REQ-005 reset  in  1  asynchronous, active-high reset.
- REQ-006 load_en  in  1  memory write strobe, honoured only in IDLE.
- REQ-007 load_addr  in  5  memory write address.
- REQ-008 load_data  in  32  memory write data.
- REQ-009 load_done  in  1  single-cycle pulse ending the load phase.
- REQ-010 resume  in  1  single-cycle pulse leaving HALT.
- REQ-011 prog_addr  in  5  fetch address from the program counter.
- REQ-012 instr  out  32  registered fetched instruction.
- REQ-013 OPCODE  out  7  equals instr[6:0] at all times, fed back to the program counter.
- REQ-014 instr_valid  out  1  high when instr holds a fetched word.
- REQ-015 halted  out  1  high while in HALT.
- REQ-016 fetch_count  out  8  number of valid fetches since reset.

Function
- REQ-017 The unit SHALL contain a 32 x 32-bit instruction memory with a synchronous write port and a registered read path.
- REQ-018 The FSM SHALL have states IDLE, RUN and HALT, encoded as a registered state.
- REQ-019 In IDLE: load_en=1 writes load_data to mem[load_addr] at the clock edge; instr = NOP_WORD; instr_valid = 0.
- REQ-020 IDLE->RUN on load_done=1; if load_en and load_done are both high in the same cycle, the write SHALL complete before the transition.
- REQ-021 In RUN: instr <= mem[prog_addr] at every edge, which is one cycle of latency; instr_valid = 1 from the first edge after entering RUN.
- REQ-022 A write and a fetch of the same address SHALL never coincide, because writes occur only in IDLE.
- REQ-023 In RUN, a word fetched with [6:0] == HALT_OP SHALL be registered into instr, and the FSM SHALL move to HALT on that same edge.
- REQ-024 In HALT: instr, OPCODE and fetch_count hold; halted = 1; instr_valid = 1; prog_addr is ignored.
- REQ-025 HALT->RUN on resume=1; on that edge instr <= NOP_WORD with instr_valid = 0, so the program counter advances past the halt word, and normal fetch restarts on the next edge.
- REQ-026 load_en and load_done SHALL be ignored in RUN and HALT; resume SHALL be ignored in IDLE and RUN.
- REQ-027 prog_addr wrap from 31 to 0 needs no special handling; mem[31] and then mem[0] are fetched on consecutive edges.
- REQ-028 fetch_count increments on every edge that produces instr_valid = 1 from a RUN-state fetch, and saturates at 255.
- REQ-029 The HALT_OP fetch that causes entry to HALT SHALL be counted; holding cycles in HALT SHALL NOT be counted.

Reset
- REQ-030 Asserting reset at any time, including mid-RUN or mid-HALT, SHALL immediately set state = IDLE, instr = NOP_WORD, OPCODE = 0, instr_valid = 0, halted = 0, fetch_count = 0.
- REQ-031 Memory contents SHALL NOT be cleared by reset; after reset a load_done pulse alone is sufficient to rerun the stored program.

Verification
- REQ-032 Load: in IDLE write mem[0..3] = 32'h13, 32'h33, 32'h63, 32'h55, then pulse load_done, then drive prog_addr 0,1,2,3 -> instr = 32'h13, 32'h33, 32'h63, 32'h55, each one cycle after its address; fetch_count = 4.
- REQ-033 Halt: a fetch of 32'h55 (HALT_OP) -> halted = 1 on the same edge, OPCODE = 7'b1010101 held, and instr unchanged for 5 cycles while prog_addr changes.
- REQ-034 Resume: resume pulse in HALT -> next cycle instr = 32'h0 with instr_valid = 0 and halted = 0, then mem[prog_addr] is fetched on the following edge.
- REQ-035 Ignored strobes: load_en with addr 2 and data 32'hFF during RUN -> mem[2] stays 32'h63 on a later fetch.
- REQ-036 Reset mid-run: assert reset between edges -> all outputs go to their reset values immediately; release reset and pulse load_done -> prog_addr 1 returns 32'h33.
- REQ-037 Wrap and saturation: 300 RUN fetches with prog_addr counting 0..31 and wrapping, and no halt word in memory -> mem[31] is followed by mem[0], and fetch_count = 255.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: 32 x 32-bit program memory loaded while idle,
// then fetched one word per cycle until a halt opcode parks the unit.
module instr_fetch_unit #(
    parameter logic [6:0]  HALT_OP  = 7'b1010101,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [4:0]  load_addr,
    input  logic [31:0] load_data,
    input  logic        load_done,
    input  logic        resume,
    input  logic [4:0]  prog_addr,
    output logic [31:0] instr,
    output logic [6:0]  OPCODE,
    output logic        instr_valid,
    output logic        halted,
    output logic [7:0]  fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mem_q [32];
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic [7:0]  fetch_count_q, fetch_count_d;
    logic        mem_we_s;
    logic [31:0] fetch_word_s;

    // Memory contents survive reset, so the program can be rerun without reloading.
    assign fetch_word_s = mem_q[prog_addr];

    // Next-state, next-output and write-enable decode for the fetch FSM.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        valid_d       = valid_q;
        fetch_count_d = fetch_count_q;
        mem_we_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A write coinciding with load_done still lands on this edge.
                mem_we_s = load_en;
                instr_d  = NOP_WORD;
                valid_d  = 1'b0;
                if (load_done) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                instr_d = fetch_word_s;
                valid_d = 1'b1;
                if (fetch_count_q != 8'hFF) begin
                    fetch_count_d = fetch_count_q + 8'd1;
                end else begin
                    fetch_count_d = fetch_count_q;
                end
                // The halt word itself is registered and counted before parking.
                if (fetch_word_s[6:0] == HALT_OP) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    // Bubble one cycle so the program counter can step past the halt word.
                    state_d = ST_RUN;
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
        endcase
        halted_d = (state_d == ST_HALT);
    end

    // Synchronous write port of the instruction memory (not reset).
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            instr_q       <= NOP_WORD;
            valid_q       <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            valid_q       <= valid_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign instr       = instr_q;
    assign OPCODE      = instr_q[6:0];
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a mode/array model compared every
// cycle, plus literal expectations at the key points of each scenario.
module tb_instr_fetch_unit;

    localparam logic [6:0]  HALT_OP  = 7'b1010101;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic        load_done;
    logic        resume;
    logic [4:0]  prog_addr;
    logic [31:0] instr;
    logic [6:0]  OPCODE;
    logic        instr_valid;
    logic        halted;
    logic [7:0]  fetch_count;

    int cmp_count = 0;
    int err_count = 0;
    logic cmp_en = 1'b0;

    instr_fetch_unit #(.HALT_OP(HALT_OP), .NOP_WORD(NOP_WORD)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .load_done(load_done), .resume(resume),
        .prog_addr(prog_addr), .instr(instr), .OPCODE(OPCODE),
        .instr_valid(instr_valid), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // mode: 0 = loading, 1 = fetching, 2 = parked on a halt word
    int          m_mode  = 0;
    logic [31:0] m_mem [32];
    logic [31:0] m_instr = NOP_WORD;
    logic        m_valid = 1'b0;
    int          m_count = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode  <= 0;
            m_instr <= NOP_WORD;
            m_valid <= 1'b0;
            m_count <= 0;
        end else if (m_mode == 0) begin
            if (load_en) m_mem[load_addr] <= load_data;
            if (load_done) m_mode <= 1;
        end else if (m_mode == 1) begin
            m_instr <= m_mem[prog_addr];
            m_valid <= 1'b1;
            m_count <= (m_count < 255) ? m_count + 1 : 255;
            if (m_mem[prog_addr][6:0] == HALT_OP) m_mode <= 2;
        end else begin
            if (resume) begin
                m_mode  <= 1;
                m_instr <= NOP_WORD;
                m_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_instr", instr, m_instr);
            check("model_opcode", {25'd0, OPCODE}, {25'd0, m_instr[6:0]});
            check("model_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            check("model_halted", {31'd0, halted}, {31'd0, (m_mode == 2)});
            check("model_count", {24'd0, fetch_count}, m_count[31:0]);
        end
    end

    function automatic logic [31:0] gen_word(input int i);
        logic [31:0] w;
        w = 32'h0000_0013 | (i << 12);
        return w;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, instr, 32'h0000_0000);
        check({tag, "_opcode"}, {25'd0, OPCODE}, 32'd0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check({tag, "_count"}, {24'd0, fetch_count}, 32'd0);
    endtask

    initial begin
        logic [31:0] prog [4];
        prog[0] = 32'h13; prog[1] = 32'h33; prog[2] = 32'h63; prog[3] = 32'h55;
        reset = 1'b1; load_en = 1'b0; load_addr = 5'd0; load_data = 32'd0;
        load_done = 1'b0; resume = 1'b0; prog_addr = 5'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        check_reset_outputs("reset");

        // Load all 32 words; the last write shares its cycle with load_done.
        for (int i = 0; i < 32; i++) begin
            load_en   = 1'b1;
            load_addr = i[4:0];
            load_data = (i < 4) ? prog[i] : gen_word(i);
            load_done = (i == 31);
            @(negedge clk);
        end
        load_en = 1'b0; load_done = 1'b0;
        check("idle_valid_at_run_entry", {31'd0, instr_valid}, 32'd0);

        // Fetch 0..2; an ignored write to mem[2] and a stray resume during RUN.
        prog_addr = 5'd0;
        @(negedge clk);
        check("fetch0", instr, 32'h13);
        check("fetch0_valid", {31'd0, instr_valid}, 32'd1);
        prog_addr = 5'd1; load_en = 1'b1; load_addr = 5'd2; load_data = 32'hFF; resume = 1'b1;
        @(negedge clk);
        check("fetch1", instr, 32'h33);
        load_en = 1'b0; resume = 1'b0; prog_addr = 5'd2;
        @(negedge clk);
        check("fetch2_not_overwritten", instr, 32'h63);
        prog_addr = 5'd3;
        @(negedge clk);
        check("fetch3_halt", instr, 32'h55);
        check("halt_same_edge", {31'd0, halted}, 32'd1);
        check("count4", {24'd0, fetch_count}, 32'd4);

        // Park for 5 cycles while prog_addr wanders.
        for (int k = 0; k < 5; k++) begin
            prog_addr = 5'(10 + k);
            @(negedge clk);
            check("halt_hold_instr", instr, 32'h55);
            check("halt_hold_opcode", {25'd0, OPCODE}, 32'h55);
            check("halt_hold_count", {24'd0, fetch_count}, 32'd4);
        end

        // Resume: one NOP bubble, then fetching restarts.
        resume = 1'b1; prog_addr = 5'd4;
        @(negedge clk);
        resume = 1'b0;
        check("resume_nop", instr, 32'h0);
        check("resume_valid", {31'd0, instr_valid}, 32'd0);
        check("resume_halted", {31'd0, halted}, 32'd0);
        prog_addr = 5'd2;
        @(negedge clk);
        check("after_resume_fetch", instr, 32'h63);
        check("after_resume_count", {24'd0, fetch_count}, 32'd5);

        // Reset between edges mid-run.
        prog_addr = 5'd5;
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        reset = 1'b0;
        // Replace the halt word so the wrap run never parks; load_done alongside.
        load_en = 1'b1; load_addr = 5'd3; load_data = gen_word(3); load_done = 1'b1;
        @(negedge clk);
        load_en = 1'b0; load_done = 1'b0;
        prog_addr = 5'd1;
        @(negedge clk);
        check("rerun_fetch1", instr, 32'h33);

        // 300 fetches with wrapping address: saturation and 31 -> 0 order.
        for (int i = 0; i < 300; i++) begin
            prog_addr = 5'(i % 32);
            @(negedge clk);
            if ((i % 32) == 31) check("wrap_mem31", instr, 32'h0001_F013);
            if ((i % 32) == 0 && i > 0) check("wrap_mem0", instr, 32'h13);
        end
        check("count_saturated", {24'd0, fetch_count}, 32'd255);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
